// File: rtl/joy_pkg.sv
// Shared definitions for the joystick direction filter: bit positions,
// restriction-mode encodings and the direction priority encoder.
package joy_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        JMODE_8WAY = 2'b00,
        JMODE_4WAY = 2'b01,
        JMODE_2H   = 2'b10,
        JMODE_2V   = 2'b11
    } jmode_e;

    localparam logic [3:0] MASK_ALL = 4'b1111;
    localparam logic [3:0] MASK_H   = 4'b0011;
    localparam logic [3:0] MASK_V   = 4'b1100;

    // One-hot of the highest-priority set bit: up > down > left > right.
    function automatic logic [3:0] prio_onehot(input logic [3:0] v);
        prio_onehot = 4'b0000;
        if (v[DIR_UP])
            prio_onehot[DIR_UP] = 1'b1;
        else if (v[DIR_DOWN])
            prio_onehot[DIR_DOWN] = 1'b1;
        else if (v[DIR_LEFT])
            prio_onehot[DIR_LEFT] = 1'b1;
        else if (v[DIR_RIGHT])
            prio_onehot[DIR_RIGHT] = 1'b1;
    endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// One player's direction path: synchroniser, per-bit debounce, rise
// detection, restriction mask and registered outputs.
module joy_dir_chan
    import joy_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 4,
    parameter int DEB_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_deb,
    input  logic [3:0] dir_i,
    input  logic [1:0] mode_i,
    output logic [3:0] dir_o,
    output logic [3:0] dir_new_o
);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_s;
    logic [3:0] stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= 4'b0000;
        end else begin
            sync_q[0] <= dir_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEB_CNT == 0) begin : g_nodeb
            logic [3:0] stable_q;
            logic       unused_ce;
            assign unused_ce = ce_deb;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    stable_q <= 4'b0000;
                else
                    stable_q <= sync_s;
            end
            assign stable = stable_q;
        end else begin : g_deb
            for (genvar gi = 0; gi < 4; gi++) begin : g_bit
                logic [DEB_W-1:0] cnt_q, cnt_d;
                logic             stable_q, stable_d;

                // Any cycle where the input agrees with the accepted level restarts the count.
                always_comb begin
                    cnt_d    = cnt_q;
                    stable_d = stable_q;
                    if (sync_s[gi] == stable_q) begin
                        cnt_d = '0;
                    end else if (ce_deb) begin
                        if (cnt_q == DEB_W'(DEB_CNT - 1)) begin
                            stable_d = sync_s[gi];
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q    <= '0;
                        stable_q <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_d;
                        stable_q <= stable_d;
                    end
                end
                assign stable[gi] = stable_q;
            end
        end
    endgenerate

    logic [3:0] prev_q, mask_q, mask_d, out_q, out_d, new_q, rise, allowed;
    logic [1:0] mode_q;

    always_comb begin
        rise    = stable & ~prev_q;
        allowed = MASK_ALL;
        mask_d  = (mode_i != mode_q) ? MASK_ALL : mask_q;
        out_d   = stable;
        case (mode_i)
            JMODE_2H: allowed = MASK_H;
            JMODE_2V: allowed = MASK_V;
            default:  allowed = MASK_ALL;
        endcase
        if (mode_i == JMODE_8WAY) begin
            mask_d = MASK_ALL;
            if (stable[DIR_UP] && stable[DIR_DOWN]) begin
                out_d[DIR_UP]   = 1'b0;
                out_d[DIR_DOWN] = 1'b0;
            end
            if (stable[DIR_LEFT] && stable[DIR_RIGHT]) begin
                out_d[DIR_LEFT]  = 1'b0;
                out_d[DIR_RIGHT] = 1'b0;
            end
        end else begin
            if ((rise & allowed) != 4'b0000)
                mask_d = prio_onehot(rise & allowed);
            // Reopen only once everything is released so the output never goes multi-hot.
            if (stable == 4'b0000)
                mask_d = MASK_ALL;
            out_d = stable & mask_d & allowed;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 4'b0000;
            mask_q <= MASK_ALL;
            out_q  <= 4'b0000;
            new_q  <= 4'b0000;
            mode_q <= JMODE_8WAY;
        end else begin
            prev_q <= stable;
            mask_q <= mask_d;
            out_q  <= out_d;
            new_q  <= rise;
            mode_q <= mode_i;
        end
    end

    assign dir_o     = out_q;
    assign dir_new_o = new_q;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction filter: one independent channel per player,
// each owning a 4-bit slice of the direction buses and a 2-bit mode slice.
module joy_dir_filter #(
    parameter int NPLAYERS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 4,
    parameter int DEB_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_deb,
    input  logic [4*NPLAYERS-1:0] dir_in,
    input  logic [2*NPLAYERS-1:0] mode,
    output logic [4*NPLAYERS-1:0] dir_out,
    output logic [4*NPLAYERS-1:0] dir_new
);

    generate
        for (genvar gi = 0; gi < NPLAYERS; gi++) begin : g_player
            joy_dir_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CNT     (DEB_CNT),
                .DEB_W       (DEB_W)
            ) u_chan (
                .clk       (clk),
                .reset_n   (reset_n),
                .ce_deb    (ce_deb),
                .dir_i     (dir_in[4*gi +: 4]),
                .mode_i    (mode[2*gi +: 2]),
                .dir_o     (dir_out[4*gi +: 4]),
                .dir_new_o (dir_new[4*gi +: 4])
            );
        end
    endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: two instances (no debounce / DEB_CNT=4) driven by
// shared stimulus, checked every cycle against a behavioural model plus literals.
module tb_joy_dir_filter;

    localparam int NP = 2;
    localparam int SS = 2;

    logic       clk;
    logic       reset_n;
    logic       ce_deb;
    logic [7:0] dir_in;
    logic [3:0] mode;
    logic [7:0] out0, new0, out4, new4;

    int checks   = 0;
    int failures = 0;

    joy_dir_filter #(.NPLAYERS(NP), .SYNC_STAGES(SS), .DEB_CNT(0), .DEB_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce_deb(ce_deb), .dir_in(dir_in),
        .mode(mode), .dir_out(out0), .dir_new(new0));

    joy_dir_filter #(.NPLAYERS(NP), .SYNC_STAGES(SS), .DEB_CNT(4), .DEB_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .ce_deb(ce_deb), .dir_in(dir_in),
        .mode(mode), .dir_out(out4), .dir_new(new4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Behavioural model: d=0 is the undebounced instance, d=1 the DEB_CNT=4 one.
    logic [7:0] hist_q[$];
    logic [3:0] m_st  [2][NP];
    logic [3:0] m_pv  [2][NP];
    logic [3:0] m_out [2][NP];
    logic [3:0] m_new [2][NP];
    logic [1:0] m_mprev [2][NP];
    int         m_sel [2][NP];
    int         m_run [2][NP][4];
    logic [7:0] m_syncv;

    task automatic model_step(input int d, input int p, input logic [3:0] sv, input logic [1:0] md);
        logic [3:0] allowed, rise, rc, o, st;
        int deb;
        deb     = (d == 0) ? 0 : 4;
        allowed = (md == 2'b10) ? 4'b0011 : (md == 2'b11) ? 4'b1100 : 4'b1111;
        st      = m_st[d][p];
        rise    = st & ~m_pv[d][p];
        if (md == 2'b00) begin
            m_sel[d][p] = -1;
            o = st;
            if (o[3] && o[2]) o[3:2] = 2'b00;
            if (o[1] && o[0]) o[1:0] = 2'b00;
        end else begin
            rc = rise & allowed;
            if (rc != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (rc[b]) m_sel[d][p] = b;
            end else if (md != m_mprev[d][p] || st == 4'b0000) begin
                m_sel[d][p] = -1;
            end
            o = ((m_sel[d][p] < 0) ? st : (st & (4'b0001 << m_sel[d][p]))) & allowed;
        end
        m_out[d][p]   = o;
        m_new[d][p]   = rise;
        m_mprev[d][p] = md;
        m_pv[d][p]    = st;
        for (int b = 0; b < 4; b++) begin
            if (deb == 0) begin
                st[b] = sv[b];
            end else if (sv[b] == st[b]) begin
                m_run[d][p][b] = 0;
            end else if (ce_deb) begin
                m_run[d][p][b]++;
                if (m_run[d][p][b] == deb) begin
                    st[b] = sv[b];
                    m_run[d][p][b] = 0;
                end
            end
        end
        m_st[d][p] = st;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q = {};
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NP; p++) begin
                    m_st[d][p] = 4'b0000; m_pv[d][p] = 4'b0000;
                    m_out[d][p] = 4'b0000; m_new[d][p] = 4'b0000;
                    m_mprev[d][p] = 2'b00; m_sel[d][p] = -1;
                    for (int b = 0; b < 4; b++) m_run[d][p][b] = 0;
                end
        end else begin
            m_syncv = (hist_q.size() >= SS) ? hist_q[SS-1] : 8'h00;
            hist_q.push_front(dir_in);
            if (hist_q.size() > SS) void'(hist_q.pop_back());
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NP; p++)
                    model_step(d, p, m_syncv[4*p +: 4], mode[2*p +: 2]);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_out_deb0", out0, {m_out[0][1], m_out[0][0]});
            chk("model_new_deb0", new0, {m_new[0][1], m_new[0][0]});
            chk("model_out_deb4", out4, {m_out[1][1], m_out[1][0]});
            chk("model_new_deb4", new4, {m_new[1][1], m_new[1][0]});
        end
    end

    task automatic ce_pulse();
        ce_deb = 1'b1;
        tick();
        ce_deb = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        ce_deb  = 1'b0;
        dir_in  = 8'h00;
        mode    = 4'h0;
        repeat (3) tick();
        chk("reset_out0", out0, 8'h00);
        chk("reset_new0", new0, 8'h00);
        chk("reset_out4", out4, 8'h00);
        reset_n = 1'b1;
        tick();

        // Debounce: 3 ticks then drop is rejected, 4 ticks accepted.
        dir_in = 8'h01;
        repeat (4) tick();
        repeat (3) ce_pulse();
        dir_in = 8'h00;
        repeat (4) tick();
        repeat (2) ce_pulse();
        chk("deb_short_pulse", out4, 8'h00);
        dir_in = 8'h01;
        repeat (4) tick();
        repeat (3) ce_pulse();
        chk("deb_3_ticks", out4, 8'h00);
        ce_deb = 1'b1;
        tick();
        ce_deb = 1'b0;
        chk("deb_4th_tick_edge", out4, 8'h00);
        tick();
        chk("deb_4_ticks_out", out4, 8'h01);
        chk("deb_4_ticks_new", new4, 8'h01);
        dir_in = 8'h00;
        repeat (5) tick();

        // Latency with no debounce: 3 clocks from the capturing edge.
        dir_in = 8'h01;
        repeat (3) tick();
        chk("lat_before", out0, 8'h00);
        tick();
        chk("lat_out", out0, 8'h01);
        chk("lat_new", new0, 8'h01);
        tick();
        chk("lat_new_1clk", new0, 8'h00);
        dir_in = 8'h00;
        repeat (5) tick();

        // 4-way on player 0.
        mode = 4'b0001;
        dir_in = 8'h01; repeat (5) tick(); chk("w4_right", out0, 8'h01);
        dir_in = 8'h09; repeat (5) tick(); chk("w4_add_up", out0, 8'h08);
        dir_in = 8'h01; repeat (5) tick(); chk("w4_rel_up", out0, 8'h00);
        dir_in = 8'h00; repeat (5) tick(); chk("w4_rel_all", out0, 8'h00);
        dir_in = 8'h02; repeat (5) tick(); chk("w4_left", out0, 8'h02);

        // 8-way SOCD neutral.
        mode = 4'b0000;
        dir_in = 8'h03; repeat (5) tick(); chk("socd_lr", out0, 8'h00);
        dir_in = 8'h0B; repeat (5) tick(); chk("socd_up_lr", out0, 8'h08);
        dir_in = 8'h00; repeat (5) tick();

        // 2-way horizontal, then switch to 8-way while held.
        mode = 4'b0010;
        dir_in = 8'h08; repeat (5) tick(); chk("h2_up_only", out0, 8'h00);
        dir_in = 8'h09; repeat (5) tick(); chk("h2_up_right", out0, 8'h01);
        mode = 4'b0000; repeat (2) tick(); chk("h2_to_8way", out0, 8'h09);
        dir_in = 8'h00; repeat (5) tick();

        // Two players, different modes, then asynchronous reset mid-hold.
        mode = 4'b0001;
        dir_in = 8'hAA; repeat (5) tick();
        chk("two_players", out0, 8'hA8);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_out0", out0, 8'h00);
        chk("async_reset_new0", new0, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) tick();
        chk("requal_new", new0, 8'hAA);
        chk("requal_out", out0, 8'hA8);
        tick();
        chk("requal_new_1clk", new0, 8'h00);

        // Randomised soak against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)
                dir_in[$urandom_range(0, 7)] = ~dir_in[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0)
                dir_in = dir_in ^ (8'h01 << $urandom_range(0, 7));
            ce_deb = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0)
                mode = 4'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
